commit_unit: RTL
================

// Module: commit_unit
// PURPOSE
//  Retirement-side counterpart of the reorder buffer: consumes the ROB commit stream one entry per cycle and drives architectural updates.
//  Writes results to the register file, releases committed stores to the LSB, trains the branch predictor and trains nothing else.
//  On a branch or jump mispredict it raises a one-cycle global flush (clear_branch) and redirects fetch.
//  Sits between ROB and regfile / LSB / fetch / predictor.
// PARAMETERS
//  ROB_IDX_W   4   ROB index width; entries 1..2^W-1, index 0 unused
//  REG_IDX_W   5   architectural register index width
//  WORD_W      32  data width
//  ADDR_W      32  PC / address width
//  ID_W        6   instruction-id width
//  BR_ID_LO    -   lowest instr_id of conditional branches; BR_ID_HI is the highest (range inclusive)
//  JMP_ID_LO   -   lowest instr_id of JAL/JALR; JMP_ID_HI is the highest (range inclusive)
//  ST_ID_LO    -   lowest instr_id of stores; ST_ID_HI is the highest (range inclusive)
// PORTS
//  clk_in              in   1          clock, all state on rising edge
//  rst_in              in   1          asynchronous, active-low reset
//  rdy_in              in   1          global enable; low = hold all state
//  commit_en_in        in   1          ROB entry valid this cycle
//  instr_id_in         in   ID_W       committed instruction id
//  rd_in               in   REG_IDX_W  destination register
//  rob_pos_in          in   ROB_IDX_W  ROB slot of committed entry
//  res_in              in   WORD_W     result value
//  jump_en_in          in   1          resolved taken
//  jump_a_in           in   ADDR_W     resolved target
//  pc_in               in   ADDR_W     instruction PC
//  bp_in               in   1          predicted taken
//  rf_we_out           out  1          regfile write strobe
//  rf_rd_out           out  REG_IDX_W  write index
//  rf_data_out         out  WORD_W     write data
//  rf_rob_pos_out      out  ROB_IDX_W  tag; regfile clears busy only if tag matches
//  lsb_st_commit_out   out  1          store at lsb_rob_pos_out may write memory
//  lsb_rob_pos_out     out  ROB_IDX_W  ROB slot of the committed store
//  bp_upd_en_out       out  1          predictor update strobe
//  bp_pc_out           out  ADDR_W     PC to train
//  bp_taken_out        out  1          actual outcome
//  clear_branch_out    out  1          global flush pulse to ROB/RS/LSB/issue
//  redirect_en_out     out  1          fetch redirect strobe, coincident with the flush
//  redirect_a_out      out  ADDR_W     new fetch PC
//  commit_cnt_out      out  32         retired-instruction count
//  mispred_cnt_out     out  32         mispredict count
// BEHAVIOUR
//  Reset: state=RUN; all strobes 0; data outputs 0; counters 0.
//  rdy_in low: no register changes; outputs hold their values.
//  Latency: every output is registered. Input sampled at edge N appears at N+1. Strobes are single-cycle unless re-triggered.
//  Classification of instr_id: ctl = BR or JMP range; st = ST range; wr = !ctl_br && !st && rd_in!=0.
//    JAL/JALR write the link register: wr applies to them too.
//  FSM RUN: on a commit:
//    - commit_cnt += 1.
//    - wr: rf_we=1, rf_rd=rd, rf_data=res, rf_rob_pos=rob_pos.
//    - st: lsb_st_commit=1, lsb_rob_pos=rob_pos.
//    - ctl: bp_upd_en=1, bp_pc=pc, bp_taken=jump_en.
//    - ctl && jump_en!=bp: clear_branch=1, redirect_en=1, mispred_cnt += 1, next state=FLUSH.
//    - redirect_a = jump_en ? jump_a : pc+4, computed modulo 2^ADDR_W.
//  FSM FLUSH, lasting exactly 1 cycle (the cycle clear_branch_out is high):
//    - Any commit_en_in is younger, wrong-path work: discard it with no writes and no count.
//    - All strobes drop to 0. Return to RUN.
//  An older write that retires alongside a mispredict still happens. The regfile write and the flush can be high in the same cycle.
//  Counters wrap from 2^32-1 to 0 silently.
//  rd_in==0 never asserts rf_we_out.
//  Reset asserted mid-FLUSH: state and outputs clear asynchronously and immediately.
// TESTING
//  1. ALU commit rd=5 res=0xDEADBEEF pos=3 -> next cycle rf_we=1 rd=5 data=0xDEADBEEF tag=3; commit_cnt=1.
//  2. Store commit pos=7, then a commit with rd=0 -> lsb_st_commit=1 pos=7; no rf_we for either commit.
//  3. Branch pc=0x100 bp=0, jump_en=1, a=0x200 -> clear=1, redirect=0x200, bp_upd taken=1, mispred_cnt=1.
//     Next-cycle ALU commit is ignored.
//  4. Branch pc=0x100 bp=1, jump_en=0 -> redirect=0x104. Correct prediction -> no clear, bp_upd only.
//  5. Hold rdy_in=0 for 3 cycles with commit_en_in=1 -> outputs frozen, counters unchanged; rdy_in=1 resumes.
//  6. Assert rst_in low in FLUSH -> clear_branch_out falls without waiting for a clock edge. Preload commit_cnt to 0xFFFFFFFF, commit once -> 0.

Source files
------------

// File: rtl/commit_unit.sv
// Retirement stage: drains the ROB commit stream into regfile writes, store releases,
// predictor training and the mispredict flush/redirect.
module commit_unit #(
   parameter int unsigned ROB_IDX_W = 4,
   parameter int unsigned REG_IDX_W = 5,
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned ID_W      = 6,
   parameter int unsigned BR_ID_LO  = 10,
   parameter int unsigned BR_ID_HI  = 15,
   parameter int unsigned JMP_ID_LO = 16,
   parameter int unsigned JMP_ID_HI = 17,
   parameter int unsigned ST_ID_LO  = 20,
   parameter int unsigned ST_ID_HI  = 22
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 commit_en_in,
   input  logic [ID_W-1:0]      instr_id_in,
   input  logic [REG_IDX_W-1:0] rd_in,
   input  logic [ROB_IDX_W-1:0] rob_pos_in,
   input  logic [WORD_W-1:0]    res_in,
   input  logic                 jump_en_in,
   input  logic [ADDR_W-1:0]    jump_a_in,
   input  logic [ADDR_W-1:0]    pc_in,
   input  logic                 bp_in,
   output logic                 rf_we_out,
   output logic [REG_IDX_W-1:0] rf_rd_out,
   output logic [WORD_W-1:0]    rf_data_out,
   output logic [ROB_IDX_W-1:0] rf_rob_pos_out,
   output logic                 lsb_st_commit_out,
   output logic [ROB_IDX_W-1:0] lsb_rob_pos_out,
   output logic                 bp_upd_en_out,
   output logic [ADDR_W-1:0]    bp_pc_out,
   output logic                 bp_taken_out,
   output logic                 clear_branch_out,
   output logic                 redirect_en_out,
   output logic [ADDR_W-1:0]    redirect_a_out,
   output logic [31:0]          commit_cnt_out,
   output logic [31:0]          mispred_cnt_out
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic {
      S_RUN,
      S_FLUSH
   } state_t;

   state_t state_q, state_d;

   logic                 rf_we_d;
   logic [REG_IDX_W-1:0] rf_rd_d;
   logic [WORD_W-1:0]    rf_data_d;
   logic [ROB_IDX_W-1:0] rf_rob_pos_d;
   logic                 lsb_st_commit_d;
   logic [ROB_IDX_W-1:0] lsb_rob_pos_d;
   logic                 bp_upd_en_d;
   logic [ADDR_W-1:0]    bp_pc_d;
   logic                 bp_taken_d;
   logic                 clear_branch_d;
   logic                 redirect_en_d;
   logic [ADDR_W-1:0]    redirect_a_d;
   logic [CNT_W-1:0]     commit_cnt_d;
   logic [CNT_W-1:0]     mispred_cnt_d;

   // Instruction class decode from the id ranges
   logic is_br, is_jmp, is_ctl, is_st, is_wr, is_mispred;

   always_comb begin
      is_br      = (instr_id_in >= ID_W'(BR_ID_LO))  && (instr_id_in <= ID_W'(BR_ID_HI));
      is_jmp     = (instr_id_in >= ID_W'(JMP_ID_LO)) && (instr_id_in <= ID_W'(JMP_ID_HI));
      is_st      = (instr_id_in >= ID_W'(ST_ID_LO))  && (instr_id_in <= ID_W'(ST_ID_HI));
      is_ctl     = is_br || is_jmp;
      is_wr      = !is_br && !is_st && (rd_in != '0);
      is_mispred = is_ctl && (jump_en_in != bp_in);
   end

   // Next-state and next-output logic; strobes default low, payloads hold
   always_comb begin
      state_d         = state_q;
      rf_we_d         = 1'b0;
      rf_rd_d         = rf_rd_out;
      rf_data_d       = rf_data_out;
      rf_rob_pos_d    = rf_rob_pos_out;
      lsb_st_commit_d = 1'b0;
      lsb_rob_pos_d   = lsb_rob_pos_out;
      bp_upd_en_d     = 1'b0;
      bp_pc_d         = bp_pc_out;
      bp_taken_d      = bp_taken_out;
      clear_branch_d  = 1'b0;
      redirect_en_d   = 1'b0;
      redirect_a_d    = redirect_a_out;
      commit_cnt_d    = commit_cnt_out;
      mispred_cnt_d   = mispred_cnt_out;

      case (state_q)
         S_RUN: begin
            if (commit_en_in) begin
               commit_cnt_d = commit_cnt_out + CNT_W'(1);
               if (is_wr) begin
                  rf_we_d      = 1'b1;
                  rf_rd_d      = rd_in;
                  rf_data_d    = res_in;
                  rf_rob_pos_d = rob_pos_in;
               end
               if (is_st) begin
                  lsb_st_commit_d = 1'b1;
                  lsb_rob_pos_d   = rob_pos_in;
               end
               if (is_ctl) begin
                  bp_upd_en_d = 1'b1;
                  bp_pc_d     = pc_in;
                  bp_taken_d  = jump_en_in;
               end
               if (is_mispred) begin
                  clear_branch_d = 1'b1;
                  redirect_en_d  = 1'b1;
                  redirect_a_d   = jump_en_in ? jump_a_in : (pc_in + ADDR_W'(4));
                  mispred_cnt_d  = mispred_cnt_out + CNT_W'(1);
                  state_d        = S_FLUSH;
               end
            end
         end
         // Anything arriving during the flush cycle is wrong-path and dropped
         S_FLUSH: state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q           <= S_RUN;
         rf_we_out         <= 1'b0;
         rf_rd_out         <= '0;
         rf_data_out       <= '0;
         rf_rob_pos_out    <= '0;
         lsb_st_commit_out <= 1'b0;
         lsb_rob_pos_out   <= '0;
         bp_upd_en_out     <= 1'b0;
         bp_pc_out         <= '0;
         bp_taken_out      <= 1'b0;
         clear_branch_out  <= 1'b0;
         redirect_en_out   <= 1'b0;
         redirect_a_out    <= '0;
         commit_cnt_out    <= '0;
         mispred_cnt_out   <= '0;
      end else if (rdy_in) begin
         state_q           <= state_d;
         rf_we_out         <= rf_we_d;
         rf_rd_out         <= rf_rd_d;
         rf_data_out       <= rf_data_d;
         rf_rob_pos_out    <= rf_rob_pos_d;
         lsb_st_commit_out <= lsb_st_commit_d;
         lsb_rob_pos_out   <= lsb_rob_pos_d;
         bp_upd_en_out     <= bp_upd_en_d;
         bp_pc_out         <= bp_pc_d;
         bp_taken_out      <= bp_taken_d;
         clear_branch_out  <= clear_branch_d;
         redirect_en_out   <= redirect_en_d;
         redirect_a_out    <= redirect_a_d;
         commit_cnt_out    <= commit_cnt_d;
         mispred_cnt_out   <= mispred_cnt_d;
      end
   end

endmodule
